// File: rtl/mul_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_pkg : shared state encoding and counter sizing for mul_seq_signed
// Revision 1.0
// ---------------------------------------------------------------------------
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mul_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_counter : loadable down-counter with zero flag (step counter)
// Revision 1.0
// ---------------------------------------------------------------------------
module mul_counter #(
   parameter int CNT_W = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/mul_seq_signed.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_seq_signed : sequential shift-add multiplier, signed/unsigned per op
// Revision 1.0
// ---------------------------------------------------------------------------
module mul_seq_signed
   import mul_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               St,
   input  logic               Signed,
   input  logic [WIDTH-1:0]   Multiplicando,
   input  logic [WIDTH-1:0]   Multiplicador,
   output logic [2*WIDTH-1:0] Produto,
   output logic               Busy,
   output logic               Done
);

   localparam int               CNT_W = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t             state;
   state_t             state_nxt;
   logic               load;
   logic               step;
   logic               finish;
   logic [CNT_W-1:0]   count;
   logic               cnt_zero;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic               neg;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc;

   logic               a_neg_in;
   logic               b_neg_in;
   logic [WIDTH-1:0]   a_abs_in;
   logic [WIDTH-1:0]   b_abs_in;

   mul_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .Clk      (Clk),
      .Reset    (Reset),
      .load     (load),
      .load_val (LAST),
      .dec      (step),
      .count    (count),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (St) begin
               load      = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (cnt_zero) begin
               state_nxt = FIX;
            end
         end
         FIX: begin
            finish    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // -2^(W-1) negates to itself, which is its correct unsigned magnitude
   assign a_neg_in = Signed & Multiplicando[WIDTH-1];
   assign b_neg_in = Signed & Multiplicador[WIDTH-1];
   assign a_abs_in = a_neg_in ? -Multiplicando : Multiplicando;
   assign b_abs_in = b_neg_in ? -Multiplicador : Multiplicador;

   assign sum = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : '0);
   assign acc = {hi, lo};

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         a_mag   <= '0;
         hi      <= '0;
         lo      <= '0;
         neg     <= 1'b0;
         Produto <= '0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
      end else begin
         Busy <= (state_nxt != IDLE);
         Done <= finish;
         if (load) begin
            a_mag <= a_abs_in;
            hi    <= '0;
            lo    <= b_abs_in;
            neg   <= a_neg_in ^ b_neg_in;
         end else if (step) begin
            hi <= sum[WIDTH:1];
            lo <= {sum[0], lo[WIDTH-1:1]};
         end
         if (finish) begin
            Produto <= neg ? -acc : acc;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_signed.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mul_seq_signed : self-checking bench, WIDTH=16 suite plus WIDTH=8/32 random
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mul_seq_signed;

   logic        clk;
   logic        rst_n;

   logic        st,  sgn;
   logic [15:0] a,   b;
   logic [31:0] prod;
   logic        busy, done;

   logic        st8, sgn8;
   logic [7:0]  a8,  b8;
   logic [15:0] prod8;
   logic        busy8, done8;

   logic        st32, sgn32;
   logic [31:0] a32, b32;
   logic [63:0] prod32;
   logic        busy32, done32;

   int tests;
   int fails;

   mul_seq_signed #(.WIDTH(16)) dut (
      .Clk(clk), .Reset(rst_n), .St(st), .Signed(sgn),
      .Multiplicando(a), .Multiplicador(b),
      .Produto(prod), .Busy(busy), .Done(done)
   );

   mul_seq_signed #(.WIDTH(8)) dut8 (
      .Clk(clk), .Reset(rst_n), .St(st8), .Signed(sgn8),
      .Multiplicando(a8), .Multiplicador(b8),
      .Produto(prod8), .Busy(busy8), .Done(done8)
   );

   mul_seq_signed #(.WIDTH(32)) dut32 (
      .Clk(clk), .Reset(rst_n), .St(st32), .Signed(sgn32),
      .Multiplicando(a32), .Multiplicador(b32),
      .Produto(prod32), .Busy(busy32), .Done(done32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: exact product of the operands read as signed or unsigned w-bit values
   function automatic logic [63:0] ref_prod(input int w, input logic s,
                                            input logic [31:0] x, input logic [31:0] y);
      longint     sx, sy;
      logic [63:0] p, mask;
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
      if (s) begin
         sx = (sx << (64 - w)) >>> (64 - w);
         sy = (sy << (64 - w)) >>> (64 - w);
      end
      p    = 64'(sx * sy);
      mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
      return p & mask;
   endfunction

   function automatic logic [31:0] pick(input int w);
      logic [31:0] v, m;
      m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      v = $urandom;
      case ($urandom_range(0, 7))
         0:       v = 32'd1 << (w - 1);
         1:       v = 32'hFFFF_FFFF;
         2:       v = 32'd0;
         3:       v = (32'd1 << (w - 1)) - 32'd1;
         default: ;
      endcase
      return v & m;
   endfunction

   task automatic run16(input logic s, input logic [15:0] x, input logic [15:0] y,
                        output logic [31:0] p, output int lat);
      @(posedge clk); #1;
      st = 1'b1; sgn = s; a = x; b = y;
      @(posedge clk); #1;
      st  = 1'b0;
      lat = 0;
      p   = 'x;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
         if (done) begin
            p = prod;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      st = 1'b0; sgn = 1'b0; a = '0; b = '0;
      st8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
      st32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, expected 0", done); end
      tests++; if (prod !== 32'd0) begin fails++; $display("FAIL reset_prod: got %h, expected 0", prod); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic        s;
      logic [15:0] x, y;
      logic [31:0] e, p;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         case (i)
            0:       begin s = 1'b0; x = 16'd3;    y = 16'd5;    e = 32'h0000_000F; end
            1:       begin s = 1'b0; x = 16'hFFFF; y = 16'hFFFF; e = 32'hFFFE_0001; end
            2:       begin s = 1'b1; x = 16'hFFFF; y = 16'hFFFF; e = 32'h0000_0001; end
            3:       begin s = 1'b1; x = 16'h8000; y = 16'h8000; e = 32'h4000_0000; end
            4:       begin s = 1'b1; x = 16'hFFFD; y = 16'd5;    e = 32'hFFFF_FFF1; end
            default: begin s = 1'b1; x = 16'h8000; y = 16'd1;    e = 32'hFFFF_8000; end
         endcase
         run16(s, x, y, p, lat);
         tests++;
         if (p !== e) begin
            fails++;
            $display("FAIL directed_%0d %h*%h s=%0d: got %h, expected %h", i, x, y, s, p, e);
         end
         tests++;
         if (lat != 17) begin
            fails++;
            $display("FAIL latency_%0d: got %0d edges, expected 17", i, lat);
         end
      end
   endtask

   task automatic test_handshake();
      logic [31:0] p;
      int          lat;
      @(posedge clk); #1;
      st = 1'b1; sgn = 1'b0; a = 16'd100; b = 16'd200;
      @(posedge clk); #1;
      st  = 1'b0;
      lat = 0;
      repeat (3) begin @(posedge clk); lat++; end
      #1;
      st = 1'b1; sgn = 1'b1; a = 16'hFFFF; b = 16'h7FFF;
      @(posedge clk); lat++; #1;
      st = 1'b0;
      p  = 'x;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
         if (done) begin p = prod; break; end
      end
      tests++; if (p !== 32'd20000) begin fails++; $display("FAIL ignored_start_prod: got %h, expected %h", p, 32'd20000); end
      tests++; if (lat != 17) begin fails++; $display("FAIL ignored_start_latency: got %0d, expected 17", lat); end
      repeat (5) @(posedge clk);
      #1;
      tests++; if (prod !== 32'd20000) begin fails++; $display("FAIL held_prod: got %h, expected %h", prod, 32'd20000); end
      tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL idle_after: got busy=%b done=%b, expected 0/0", busy, done); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] r;
      logic [31:0] e, p0, p1;
      int          n, t0, t1, overlap;
      r = ref_prod(16, 1'b1, 32'h0000_FFF9, 32'd11);
      e = r[31:0];
      n = 0; t0 = -1; t1 = -1; overlap = 0; p0 = 'x; p1 = 'x;
      @(posedge clk); #1;
      st = 1'b1; sgn = 1'b1; a = 16'hFFF9; b = 16'd11;
      while (n < 80 && t1 < 0) begin
         @(posedge clk);
         n++;
         #1;
         if (busy && done) overlap++;
         if (done) begin
            if (t0 < 0) begin t0 = n; p0 = prod; end
            else begin t1 = n; p1 = prod; end
         end
      end
      st = 1'b0;
      tests++; if (p0 !== e) begin fails++; $display("FAIL b2b_first: got %h, expected %h", p0, e); end
      tests++; if (p1 !== e) begin fails++; $display("FAIL b2b_second: got %h, expected %h", p1, e); end
      tests++; if (t0 != 18) begin fails++; $display("FAIL b2b_first_time: got %0d, expected 18", t0); end
      tests++; if (t1 - t0 != 18) begin fails++; $display("FAIL b2b_interval: got %0d, expected 18", t1 - t0); end
      tests++; if (overlap != 0) begin fails++; $display("FAIL busy_done_overlap: got %0d cycles, expected 0", overlap); end
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      logic [31:0] p;
      int          lat, seen;
      @(posedge clk); #1;
      st = 1'b1; sgn = 1'b0; a = 16'd1234; b = 16'd5678;
      @(posedge clk); #1;
      st = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL async_busy: got %b, expected 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL async_done: got %b, expected 0", done); end
      tests++; if (prod !== 32'd0) begin fails++; $display("FAIL async_prod: got %h, expected 0", prod); end
      seen = 0;
      repeat (20) begin @(posedge clk); #1; if (done) seen++; end
      tests++; if (seen != 0) begin fails++; $display("FAIL aborted_done: got %0d pulses, expected 0", seen); end
      rst_n = 1'b1;
      run16(1'b0, 16'd7, 16'd9, p, lat);
      tests++; if (p !== 32'd63) begin fails++; $display("FAIL post_reset_prod: got %h, expected %h", p, 32'd63); end
      tests++; if (lat != 17) begin fails++; $display("FAIL post_reset_latency: got %0d, expected 17", lat); end
   endtask

   task automatic test_random16();
      logic        s;
      logic [15:0] x, y;
      logic [31:0] e, p;
      logic [63:0] r;
      int          lat;
      for (int i = 0; i < 1000; i++) begin
         s = 1'($urandom_range(0, 1));
         x = 16'(pick(16));
         y = 16'(pick(16));
         r = ref_prod(16, s, {16'd0, x}, {16'd0, y});
         e = r[31:0];
         run16(s, x, y, p, lat);
         tests++;
         if (p !== e || lat != 17) begin
            fails++;
            $display("FAIL rand16 %h*%h s=%0d: got %h lat %0d, expected %h lat 17", x, y, s, p, lat, e);
         end
      end
   endtask

   task automatic test_random_widths();
      logic [63:0] r8, r32, p32;
      logic [15:0] e8, p8;
      logic        got8, got32;
      int          n, l8, l32;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         sgn8  = 1'($urandom_range(0, 1));
         a8    = 8'(pick(8));
         b8    = 8'(pick(8));
         sgn32 = 1'($urandom_range(0, 1));
         a32   = pick(32);
         b32   = pick(32);
         r8    = ref_prod(8, sgn8, {24'd0, a8}, {24'd0, b8});
         e8    = r8[15:0];
         r32   = ref_prod(32, sgn32, a32, b32);
         st8 = 1'b1; st32 = 1'b1;
         @(posedge clk); #1;
         st8 = 1'b0; st32 = 1'b0;
         got8 = 1'b0; got32 = 1'b0; n = 0; l8 = 0; l32 = 0; p8 = 'x; p32 = 'x;
         while (n < 50 && !(got8 && got32)) begin
            @(posedge clk);
            n++;
            #1;
            if (done8 && !got8)   begin got8 = 1'b1;  p8 = prod8;   l8 = n;  end
            if (done32 && !got32) begin got32 = 1'b1; p32 = prod32; l32 = n; end
         end
         tests++;
         if (!got8 || p8 !== e8 || l8 != 9) begin
            fails++;
            $display("FAIL rand8 %h*%h s=%0d: got %h lat %0d, expected %h lat 9", a8, b8, sgn8, p8, l8, e8);
         end
         tests++;
         if (!got32 || p32 !== r32 || l32 != 33) begin
            fails++;
            $display("FAIL rand32 %h*%h s=%0d: got %h lat %0d, expected %h lat 33", a32, b32, sgn32, p32, l32, r32);
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_directed();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      test_random16();
      test_random_widths();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
